// File: rtl/snake_pkg.sv
// Shared types and PS/2 set-2 scancodes for the snake game input path.
package snake_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_DIR,
    CMD_PAUSE,
    CMD_START
  } cmd_t;

  typedef struct packed {
    cmd_t cmd;
    dir_t dir;
  } lookup_t;

  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_UP_ARW = 8'h75;
  localparam logic [7:0] SC_DN_ARW = 8'h72;
  localparam logic [7:0] SC_LT_ARW = 8'h6B;
  localparam logic [7:0] SC_RT_ARW = 8'h74;
  localparam logic [7:0] SC_W      = 8'h1D;
  localparam logic [7:0] SC_S      = 8'h1B;
  localparam logic [7:0] SC_A      = 8'h1C;
  localparam logic [7:0] SC_D      = 8'h23;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_ENTER  = 8'h5A;

  // Maps a make code to a game command; ext selects the E0-prefixed table.
  function automatic lookup_t sc_lookup(input logic ext, input logic [7:0] code);
    lookup_t r;
    r.cmd = CMD_NONE;
    r.dir = UP;
    if (ext) begin
      case (code)
        SC_UP_ARW: begin r.cmd = CMD_DIR; r.dir = UP;    end
        SC_DN_ARW: begin r.cmd = CMD_DIR; r.dir = DOWN;  end
        SC_LT_ARW: begin r.cmd = CMD_DIR; r.dir = LEFT;  end
        SC_RT_ARW: begin r.cmd = CMD_DIR; r.dir = RIGHT; end
        default: ;
      endcase
    end else begin
      case (code)
        SC_W:     begin r.cmd = CMD_DIR; r.dir = UP;    end
        SC_S:     begin r.cmd = CMD_DIR; r.dir = DOWN;  end
        SC_A:     begin r.cmd = CMD_DIR; r.dir = LEFT;  end
        SC_D:     begin r.cmd = CMD_DIR; r.dir = RIGHT; end
        SC_SPACE: r.cmd = CMD_PAUSE;
        SC_ENTER: r.cmd = CMD_START;
        default: ;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchronizers, clock glitch filter, frame FSM and
// partial-frame timeout. Emits one-cycle byte_valid / frame_err pulses.
module ps2_frame_rx
  import snake_pkg::*;
#(
  parameter int unsigned FILT_LEN    = 4,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int unsigned FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]    clk_sync, dat_sync;
  logic          clk_filt;
  logic [FW-1:0] filt_cnt;
  logic          edge_any, edge_fall, dat_smp;

  rx_state_t     state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic          par_ok, par_ok_n;
  logic          byte_valid_n, frame_err_n;
  logic [TW-1:0] to_cnt;
  logic          timeout;

  // Pins idle high, so synchronizers and filter reset to 1 to avoid a false edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= '1;
      dat_sync  <= '1;
      clk_filt  <= 1'b1;
      filt_cnt  <= '0;
      edge_any  <= 1'b0;
      edge_fall <= 1'b0;
      dat_smp   <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      dat_sync  <= {dat_sync[0], ps2_dat};
      edge_any  <= 1'b0;
      edge_fall <= 1'b0;
      if (clk_sync[1] != clk_filt) begin
        if (filt_cnt == FW'(FILT_LEN - 1)) begin
          clk_filt  <= clk_sync[1];
          filt_cnt  <= '0;
          edge_any  <= 1'b1;
          edge_fall <= clk_filt;
          dat_smp   <= dat_sync[1];
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (state == RX_IDLE || edge_any) begin
      to_cnt <= '0;
    end else if (!timeout) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign timeout = (state != RX_IDLE) && !edge_any && (to_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RX_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_ok     <= 1'b0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shreg      <= shreg_n;
      par_ok     <= par_ok_n;
      byte_valid <= byte_valid_n;
      frame_err  <= frame_err_n;
    end
  end

  always_comb begin
    state_n      = state;
    bit_cnt_n    = bit_cnt;
    shreg_n      = shreg;
    par_ok_n     = par_ok;
    byte_valid_n = 1'b0;
    frame_err_n  = 1'b0;
    if (timeout) begin
      state_n     = RX_IDLE;
      frame_err_n = 1'b1;
    end else if (edge_fall) begin
      case (state)
        RX_IDLE: begin
          if (dat_smp) begin
            frame_err_n = 1'b1;
          end else begin
            state_n   = RX_DATA;
            bit_cnt_n = '0;
          end
        end
        RX_DATA: begin
          shreg_n   = {dat_smp, shreg[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = RX_PARITY;
        end
        RX_PARITY: begin
          par_ok_n = ^{shreg, dat_smp};
          state_n  = RX_STOP;
        end
        RX_STOP: begin
          if (dat_smp && par_ok) byte_valid_n = 1'b1;
          else                   frame_err_n  = 1'b1;
          state_n = RX_IDLE;
        end
        default: state_n = RX_IDLE;
      endcase
    end
  end

  assign rx_byte = shreg;

endmodule

// File: rtl/ps2_dir_decoder.sv
// PS/2 keyboard front end for snake_top: turns received make codes into
// one-cycle direction / pause / start commands and exports the last scancode.
module ps2_dir_decoder
  import snake_pkg::*;
#(
  parameter int unsigned FILT_LEN    = 4,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       dir_valid,
  output dir_t       dir,
  output logic       pause_pulse,
  output logic       start_pulse,
  output logic [7:0] scancode,
  output logic       frame_err
);

  logic       byte_valid;
  logic [7:0] rx_byte;
  logic       rx_err;
  logic       ext, brk;
  lookup_t    lk;

  ps2_frame_rx #(
    .FILT_LEN   (FILT_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .byte_valid(byte_valid),
    .rx_byte   (rx_byte),
    .frame_err (rx_err)
  );

  always_comb lk = sc_lookup(ext, rx_byte);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_valid   <= 1'b0;
      dir         <= UP;
      pause_pulse <= 1'b0;
      start_pulse <= 1'b0;
      scancode    <= '0;
      frame_err   <= 1'b0;
      ext         <= 1'b0;
      brk         <= 1'b0;
    end else begin
      dir_valid   <= 1'b0;
      pause_pulse <= 1'b0;
      start_pulse <= 1'b0;
      frame_err   <= rx_err;
      if (byte_valid) begin
        scancode <= rx_byte;
        if (rx_byte == SC_E0) begin
          ext <= 1'b1;
        end else if (rx_byte == SC_F0) begin
          brk <= 1'b1;
        end else begin
          // Any terminal byte closes the prefix sequence; a release emits nothing.
          ext <= 1'b0;
          brk <= 1'b0;
          if (!brk) begin
            case (lk.cmd)
              CMD_DIR: begin
                dir_valid <= 1'b1;
                dir       <= lk.dir;
              end
              CMD_PAUSE: pause_pulse <= 1'b1;
              CMD_START: start_pulse <= 1'b1;
              default: ;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_dir_decoder.sv
// Randomized scoreboard bench for ps2_dir_decoder with a key-level reference model.
module tb_ps2_dir_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk, ps2_dat;
  logic       dir_valid, pause_pulse, start_pulse, frame_err;
  logic [1:0] dir;
  logic [7:0] scancode;

  localparam int H = 8;  // half PS/2 bit period in game clocks

  ps2_dir_decoder #(.FILT_LEN(4), .TIMEOUT_CYC(50000)) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .dir_valid  (dir_valid),
    .dir        (dir),
    .pause_pulse(pause_pulse),
    .start_pulse(start_pulse),
    .scancode   (scancode),
    .frame_err  (frame_err)
  );

  always #20 clk = ~clk;

  // pulses = {frame_err, start_pulse, pause_pulse, dir_valid}
  typedef struct packed {
    logic [3:0] pulses;
    logic [1:0] dir;
    logic [7:0] sc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  logic       m_ext = 1'b0, m_brk = 1'b0;
  logic [7:0] m_sc = 8'h00;
  logic [1:0] m_dir = 2'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: keyboard semantics from the key table, per received byte.
  task automatic model_byte(input logic [7:0] b);
    int cmd;  // 0 none, 1 dir, 2 pause, 3 start
    int d;
    cmd = 0;
    d = 0;
    m_sc = b;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else if (m_brk) begin
      m_brk = 1'b0;
      m_ext = 1'b0;
    end else begin
      if (m_ext) begin
        if (b == 8'h75) begin cmd = 1; d = 0; end
        if (b == 8'h72) begin cmd = 1; d = 1; end
        if (b == 8'h6B) begin cmd = 1; d = 2; end
        if (b == 8'h74) begin cmd = 1; d = 3; end
      end else begin
        if (b == 8'h1D) begin cmd = 1; d = 0; end
        if (b == 8'h1B) begin cmd = 1; d = 1; end
        if (b == 8'h1C) begin cmd = 1; d = 2; end
        if (b == 8'h23) begin cmd = 1; d = 3; end
        if (b == 8'h29) cmd = 2;
        if (b == 8'h5A) cmd = 3;
      end
      m_ext = 1'b0;
      if (cmd == 1) m_dir = 2'(d);
      if (cmd != 0) q.push_back('{pulses: 4'(1 << (cmd - 1)), dir: m_dir, sc: m_sc});
    end
  endtask

  task automatic model_err();
    q.push_back('{pulses: 4'b1000, dir: m_dir, sc: m_sc});
  endtask

  task automatic ps2_bit(input logic b);
    ps2_dat = b;
    repeat (H) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (H) @(posedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                            input int glitch_bit);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == glitch_bit) begin
        repeat (3) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (2) @(posedge clk);
        ps2_clk = 1'b1;
      end
      ps2_bit(b[i]);
    end
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(~bad_stop);
    ps2_dat = 1'b1;
  endtask

  task automatic tx(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    if (bad_par || bad_stop) model_err();
    else model_byte(b);
    send_frame(b, bad_par, bad_stop, -1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dir_valid"}, 32'(dir_valid), 0);
    check({tag, "_dir"}, 32'(dir), 0);
    check({tag, "_pause"}, 32'(pause_pulse), 0);
    check({tag, "_start"}, 32'(start_pulse), 0);
    check({tag, "_scancode"}, 32'(scancode), 0);
    check({tag, "_frame_err"}, 32'(frame_err), 0);
  endtask

  // Monitor: every observed pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    logic [3:0] pv;
    exp_t e;
    if (rst === 1'b0) begin
      pv = {frame_err, start_pulse, pause_pulse, dir_valid};
      if (pv != 4'b0) begin
        if (q.size() == 0) begin
          check("unexpected_pulse", 32'(pv), 0);
        end else begin
          e = q.pop_front();
          check("pulses", 32'(pv), 32'(e.pulses));
          check("dir", 32'(dir), 32'(e.dir));
          check("scancode", 32'(scancode), 32'(e.sc));
        end
      end
    end
  end

  initial begin
    logic [7:0] pool[12];
    logic [7:0] b;
    int r;
    pool = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29, 8'h5A, 8'h75, 8'h72, 8'h6B, 8'h74, 8'hE0, 8'hF0};

    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (10) @(posedge clk);

    // 1: WASD up
    tx(8'h1D, 1'b0, 1'b0);
    // 2: extended right make, then its release
    tx(8'hE0, 1'b0, 1'b0);
    tx(8'h74, 1'b0, 1'b0);
    tx(8'hE0, 1'b0, 1'b0);
    tx(8'hF0, 1'b0, 1'b0);
    tx(8'h74, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    check("t2_scancode", 32'(scancode), 32'h74);
    // 3: parity error keeps the previous scancode
    tx(8'h1C, 1'b1, 1'b0);
    repeat (10) @(posedge clk);
    check("t3_scancode", 32'(scancode), 32'h74);
    // bad stop bit, then a lone bad start bit
    tx(8'h23, 1'b0, 1'b1);
    model_err();
    ps2_bit(1'b1);
    repeat (20) @(posedge clk);

    // 4: partial frame abandoned, timeout, then a pause key
    model_err();
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'(i & 1));
    ps2_dat = 1'b1;
    repeat (50020) @(posedge clk);
    tx(8'h29, 1'b0, 1'b0);

    // 5: short low glitch on ps2_clk inside the data bits
    model_byte(8'h5A);
    send_frame(8'h5A, 1'b0, 1'b0, 3);
    repeat (10) @(posedge clk);
    check("t5_scancode", 32'(scancode), 32'h5A);

    // Randomized key traffic with occasional corrupted frames
    for (int n = 0; n < 100; n++) begin
      r = $urandom_range(0, 15);
      b = (r < 12) ? pool[r] : 8'($urandom);
      r = $urandom_range(0, 19);
      tx(b, r == 0, r == 1);
    end
    repeat (40) @(posedge clk);
    check("rand_queue_drained", 32'(q.size()), 0);
    check("rand_dir_held", 32'(dir), 32'(m_dir));
    check("rand_scancode", 32'(scancode), 32'(m_sc));

    // 6: reset mid-frame after E0 clears the extended flag
    tx(8'hE0, 1'b0, 1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    repeat (3) @(posedge clk);
    rst = 1'b1;
    q.delete();
    m_ext = 1'b0;
    m_brk = 1'b0;
    m_sc = 8'h00;
    m_dir = 2'd0;
    ps2_dat = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_all_zero("midreset");
    rst = 1'b0;
    repeat (10) @(posedge clk);
    tx(8'h75, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    check("t6_scancode", 32'(scancode), 32'h75);
    check("t6_dir", 32'(dir), 0);
    check("final_queue_drained", 32'(q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
